// File: rtl/axis_frame_pattern_gen.sv
// AXI4-Stream synthetic grayscale frame source (ramp, constant, checkerboard, impulse noise)
// with tuser start-of-frame, tlast end-of-line and programmable line/frame blanking.
module axis_frame_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 1024,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic [1:0]            i_pattern,
  input  logic [DATA_WIDTH-1:0] i_const_value,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int XW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [XW-1:0]         X_ZERO    = {XW{1'b0}};
  localparam logic [YW-1:0]         Y_ZERO    = {YW{1'b0}};
  localparam logic [BW-1:0]         B_ZERO    = {BW{1'b0}};
  localparam logic [XW-1:0]         X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0]         HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0]         VB_LAST   = BW'(V_BLANK - 1);
  localparam logic [15:0]           LFSR_SEED = 16'hACE1;
  localparam logic [DATA_WIDTH-1:0] PIX_MAX   = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] PIX_MIN   = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11 (shift right, feedback into bit 15)
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pixel_value(
    input logic [1:0]            pat,
    input logic [DATA_WIDTH-1:0] cval,
    input logic [XW-1:0]         x,
    input logic [YW-1:0]         y,
    input logic [3:0]            noise
  );
    logic [DATA_WIDTH-1:0] ramp;
    ramp = DATA_WIDTH'(32'(x) + 32'(y));
    case (pat)
      2'd0: pixel_value = ramp;
      2'd1: pixel_value = cval;
      2'd2: pixel_value = (((32'(x) ^ 32'(y)) & 32'd8) != 32'd0) ? PIX_MAX : PIX_MIN;
      2'd3: begin
        if (noise == 4'h0) begin
          pixel_value = PIX_MAX;
        end else if (noise == 4'h1) begin
          pixel_value = PIX_MIN;
        end else begin
          pixel_value = ramp;
        end
      end
      default: pixel_value = ramp;
    endcase
  endfunction

  state_t                state_r, state_nxt_s;
  logic [XW-1:0]         x_r, x_nxt_s;
  logic [YW-1:0]         y_r, y_nxt_s;
  logic [BW-1:0]         blank_r, blank_nxt_s;
  logic [15:0]           lfsr_r, lfsr_nxt_s;
  logic [1:0]            pat_r, pat_nxt_s;
  logic [DATA_WIDTH-1:0] cval_r, cval_nxt_s;
  logic [DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
  logic                  tvalid_r, tvalid_nxt_s;
  logic                  tuser_r, tuser_nxt_s;
  logic                  tlast_r, tlast_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  accept_s;
  logic                  load_s;

  // Next-state, coordinate/blank counters, LFSR and next presented beat
  always_comb begin
    state_nxt_s  = state_r;
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    blank_nxt_s  = blank_r;
    lfsr_nxt_s   = lfsr_r;
    pat_nxt_s    = pat_r;
    cval_nxt_s   = cval_r;
    tdata_nxt_s  = tdata_r;
    tvalid_nxt_s = tvalid_r;
    tuser_nxt_s  = tuser_r;
    tlast_nxt_s  = tlast_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    load_s       = 1'b0;
    accept_s     = tvalid_r & m_axis_tready;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          pat_nxt_s   = i_pattern;
          cval_nxt_s  = i_const_value;
          x_nxt_s     = X_ZERO;
          y_nxt_s     = Y_ZERO;
          state_nxt_s = ST_ACTIVE;
          busy_nxt_s  = 1'b1;
          load_s      = 1'b1;
        end else begin
          busy_nxt_s   = 1'b0;
          tvalid_nxt_s = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (accept_s) begin
          lfsr_nxt_s = lfsr_step(lfsr_r);
          if (x_r != X_LAST) begin
            x_nxt_s = x_r + XW'(1);
            load_s  = 1'b1;
          end else if (y_r != Y_LAST) begin
            x_nxt_s = X_ZERO;
            y_nxt_s = y_r + YW'(1);
            if (H_BLANK > 0) begin
              state_nxt_s  = ST_HBLANK;
              blank_nxt_s  = B_ZERO;
              tvalid_nxt_s = 1'b0;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            done_nxt_s = 1'b1;
            x_nxt_s    = X_ZERO;
            y_nxt_s    = Y_ZERO;
            if (i_continuous && (V_BLANK > 0)) begin
              state_nxt_s  = ST_VBLANK;
              blank_nxt_s  = B_ZERO;
              tvalid_nxt_s = 1'b0;
            end else if (i_continuous) begin
              pat_nxt_s  = i_pattern;
              cval_nxt_s = i_const_value;
              load_s     = 1'b1;
            end else begin
              state_nxt_s  = ST_IDLE;
              busy_nxt_s   = 1'b0;
              tvalid_nxt_s = 1'b0;
            end
          end
        end else begin
          tvalid_nxt_s = tvalid_r;
        end
      end
      ST_HBLANK: begin
        if (blank_r == HB_LAST) begin
          state_nxt_s = ST_ACTIVE;
          blank_nxt_s = B_ZERO;
          load_s      = 1'b1;
        end else begin
          blank_nxt_s = blank_r + BW'(1);
        end
      end
      ST_VBLANK: begin
        if (blank_r == VB_LAST) begin
          // New frame: settings are re-latched from the inputs here
          pat_nxt_s   = i_pattern;
          cval_nxt_s  = i_const_value;
          x_nxt_s     = X_ZERO;
          y_nxt_s     = Y_ZERO;
          state_nxt_s = ST_ACTIVE;
          blank_nxt_s = B_ZERO;
          load_s      = 1'b1;
        end else begin
          blank_nxt_s = blank_r + BW'(1);
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        busy_nxt_s   = 1'b0;
        tvalid_nxt_s = 1'b0;
      end
    endcase

    if (load_s) begin
      tvalid_nxt_s = 1'b1;
      tdata_nxt_s  = pixel_value(pat_nxt_s, cval_nxt_s, x_nxt_s, y_nxt_s, lfsr_nxt_s[3:0]);
      tuser_nxt_s  = (x_nxt_s == X_ZERO) && (y_nxt_s == Y_ZERO);
      tlast_nxt_s  = (x_nxt_s == X_LAST);
    end else if (!tvalid_nxt_s) begin
      tdata_nxt_s = PIX_MIN;
      tuser_nxt_s = 1'b0;
      tlast_nxt_s = 1'b0;
    end else begin
      tdata_nxt_s = tdata_r;
      tuser_nxt_s = tuser_r;
      tlast_nxt_s = tlast_r;
    end
  end

  // State, counters, latched frame settings and registered stream outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= ST_IDLE;
      x_r      <= X_ZERO;
      y_r      <= Y_ZERO;
      blank_r  <= B_ZERO;
      lfsr_r   <= LFSR_SEED;
      pat_r    <= 2'd0;
      cval_r   <= PIX_MIN;
      tdata_r  <= PIX_MIN;
      tvalid_r <= 1'b0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      x_r      <= x_nxt_s;
      y_r      <= y_nxt_s;
      blank_r  <= blank_nxt_s;
      lfsr_r   <= lfsr_nxt_s;
      pat_r    <= pat_nxt_s;
      cval_r   <= cval_nxt_s;
      tdata_r  <= tdata_nxt_s;
      tvalid_r <= tvalid_nxt_s;
      tuser_r  <= tuser_nxt_s;
      tlast_r  <= tlast_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tuser  = tuser_r;
  assign m_axis_tlast  = tlast_r;
  assign o_busy        = busy_r;
  assign o_frame_done  = done_r;

endmodule
